// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latencies, FSM states.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    localparam int unsigned MUL_CYCLES = 5;
    localparam int unsigned DIV_CYCLES = 10;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic {
        StIdle,
        StBusy
    } mdu_state_e;

    function automatic logic [CNT_W-1:0] op_cycles(input mdu_op_e op);
        if (op == MDU_DIV || op == MDU_DIVU) begin
            return CNT_W'(DIV_CYCLES);
        end
        return CNT_W'(MUL_CYCLES);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result for the latched MDU operation; divide by zero keeps the
// current HI/LO and the signed overflow case (INT_MIN / -1) is pinned explicitly.
module mdu_calc
    import mdu_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi_cur,
    input  logic [31:0] lo_cur,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next
);

    logic        sgn;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        sgn   = (op == MDU_MULT) || (op == MDU_DIV);
        ext_a = sgn ? {{32{rs[31]}}, rs} : {32'b0, rs};
        ext_b = sgn ? {{32{rt[31]}}, rt} : {32'b0, rt};
        // Low 64 bits of the extended product are correct for both signednesses.
        prod  = ext_a * ext_b;

        mag_a = (sgn && rs[31]) ? (32'd0 - rs) : rs;
        mag_b = (sgn && rt[31]) ? (32'd0 - rt) : rt;
        uq    = (mag_b != 32'd0) ? (mag_a / mag_b) : 32'd0;
        ur    = (mag_b != 32'd0) ? (mag_a % mag_b) : 32'd0;
        // Quotient truncates toward zero; remainder follows the dividend sign.
        quo   = (sgn && (rs[31] ^ rt[31])) ? (32'd0 - uq) : uq;
        rem   = (sgn && rs[31]) ? (32'd0 - ur) : ur;

        hi_next = hi_cur;
        lo_next = lo_cur;
        unique case (op)
            MDU_MULT, MDU_MULTU: begin
                hi_next = prod[63:32];
                lo_next = prod[31:0];
            end
            MDU_DIV, MDU_DIVU: begin
                if (rt != 32'd0) begin
                    if (op == MDU_DIV && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
                        hi_next = 32'd0;
                        lo_next = 32'h8000_0000;
                    end else begin
                        hi_next = rem;
                        lo_next = quo;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MDU controller: IDLE/BUSY FSM, latency counter, operand latches and the
// architectural HI/LO registers; results commit on the edge closing the last busy cycle.
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mdu_op,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        flush,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    mdu_op_e          op_q;
    logic [31:0]      rs_q;
    logic [31:0]      rt_q;
    logic [31:0]      hi_next;
    logic [31:0]      lo_next;

    mdu_calc u_calc (
        .op      (op_q),
        .rs      (rs_q),
        .rt      (rt_q),
        .hi_cur  (hi),
        .lo_cur  (lo),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= MDU_MULT;
            rs_q    <= '0;
            rt_q    <= '0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A flushed E-stage instruction must leave no trace.
                    if (!flush) begin
                        if (start) begin
                            op_q    <= mdu_op_e'(mdu_op);
                            rs_q    <= rs_data;
                            rt_q    <= rt_data;
                            cnt_q   <= op_cycles(mdu_op_e'(mdu_op));
                            state_q <= StBusy;
                            busy    <= 1'b1;
                        end else if (mthi) begin
                            hi <= rs_data;
                        end else if (mtlo) begin
                            lo <= rs_data;
                        end
                    end
                end
                StBusy: begin
                    // Flush is deliberately ignored: the op retired ahead of the exception.
                    if (cnt_q == CNT_W'(1)) begin
                        hi      <= hi_next;
                        lo      <= lo_next;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
